systolic_tile_sequencer: RTL and testbench

- Moore FSM that sequences one tile through systolic_array: clears accumulators, streams k_blocks input blocks of SLICES cycles, waits out pipeline flush, snapshots accumulators into the out queue, then paces readout of all W*H results.
- Sits between the top-level I/O wrapper and systolic_array.
- Replaces the single !ena strobe with four individually timed control signals plus start/busy/done status.

---
 rtl/systolic_tile_sequencer.sv | 147 ++++++++++++++
 tb/tb_systolic_tile_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_sequencer.sv
// Control sequencer for one systolic_array tile: clear, feed k blocks, flush,
// snapshot accumulators, then pace readout of all W*H results.
module systolic_tile_sequencer #(
  parameter int SLICES       = 2,
  parameter int K_BITS       = 8,
  parameter int FLUSH_CYCLES = SLICES,
  localparam int N_OUT       = 2 * SLICES * SLICES,
  localparam int IDX_W       = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [K_BITS-1:0] k_blocks,
  output logic              in_ready,
  output logic              restart_inputs,
  output logic              reset_accumulators,
  output logic              copy_accumulator_values_to_out_queue,
  output logic              restart_out_queue,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_index,
  output logic              busy,
  output logic              done
);

  localparam int SL_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, PREP, FEED, FLUSH, COPY, READOUT, ABORT
  } state_t;

  state_t            state_q, state_n;
  logic [SL_W-1:0]   slice_q, slice_n;
  logic [K_BITS-1:0] blk_q, blk_n;
  logic [K_BITS-1:0] k_q, k_n;
  logic [FL_W-1:0]   flush_q, flush_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic              cancel;

  assign cancel = abort && (state_q != IDLE) && (state_q != ABORT);

  always_comb begin
    state_n = state_q;
    slice_n = slice_q;
    blk_n   = blk_q;
    k_n     = k_q;
    flush_n = flush_q;
    idx_n   = idx_q;
    if (cancel) begin
      state_n = ABORT;
      slice_n = '0;
      blk_n   = '0;
      flush_n = '0;
      idx_n   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_n = PREP;
          k_n     = k_blocks;
          slice_n = '0;
          blk_n   = '0;
          flush_n = '0;
          idx_n   = '0;
        end
        PREP: begin
          if (k_q != '0)             state_n = FEED;
          else if (FLUSH_CYCLES > 1) state_n = FLUSH;
          else                       state_n = COPY;
        end
        FEED: begin
          if (slice_q == SL_W'(SLICES - 1)) begin
            slice_n = '0;
            if (blk_q == k_q - K_BITS'(1)) begin
              blk_n   = '0;
              state_n = (FLUSH_CYCLES > 1) ? FLUSH : COPY;
            end else begin
              blk_n = blk_q + K_BITS'(1);
            end
          end else begin
            slice_n = slice_q + SL_W'(1);
          end
        end
        FLUSH: begin
          if (flush_q == FL_W'(FLUSH_CYCLES - 2)) begin
            flush_n = '0;
            state_n = COPY;
          end else begin
            flush_n = flush_q + FL_W'(1);
          end
        end
        COPY: begin
          state_n = READOUT;
          idx_n   = '0;
        end
        READOUT: begin
          if (idx_q == IDX_W'(N_OUT - 1)) begin
            idx_n   = '0;
            state_n = IDLE;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
        ABORT:   state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q                              <= IDLE;
      slice_q                              <= '0;
      blk_q                                <= '0;
      k_q                                  <= '0;
      flush_q                              <= '0;
      idx_q                                <= '0;
      in_ready                             <= 1'b0;
      restart_inputs                       <= 1'b0;
      reset_accumulators                   <= 1'b0;
      copy_accumulator_values_to_out_queue <= 1'b0;
      restart_out_queue                    <= 1'b0;
      out_valid                            <= 1'b0;
      busy                                 <= 1'b0;
      done                                 <= 1'b0;
    end else begin
      state_q                              <= state_n;
      slice_q                              <= slice_n;
      blk_q                                <= blk_n;
      k_q                                  <= k_n;
      flush_q                              <= flush_n;
      idx_q                                <= idx_n;
      in_ready                             <= (state_n == FEED);
      restart_inputs                       <= (state_n == PREP) || (state_n == COPY) || (state_n == ABORT);
      reset_accumulators                   <= (state_n == PREP) || (state_n == COPY) || (state_n == ABORT);
      copy_accumulator_values_to_out_queue <= (state_n == COPY);
      restart_out_queue                    <= (state_n == COPY);
      out_valid                            <= (state_n == READOUT);
      busy                                 <= (state_n != IDLE);
      done                                 <= (state_n == READOUT) && (idx_n == IDX_W'(N_OUT - 1));
    end
  end

  assign out_index = idx_q;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Directed bench for systolic_tile_sequencer (SLICES=2, FLUSH_CYCLES=2, K_BITS=8).
module tb_systolic_tile_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] k_blocks = '0;
  logic       in_ready, restart_inputs, reset_accumulators;
  logic       copy_accumulator_values_to_out_queue, restart_out_queue;
  logic       out_valid, busy, done;
  logic [2:0] out_index;

  int checks = 0;
  int passed = 0;

  systolic_tile_sequencer #(.SLICES(2), .K_BITS(8), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .k_blocks(k_blocks),
    .in_ready(in_ready), .restart_inputs(restart_inputs),
    .reset_accumulators(reset_accumulators),
    .copy_accumulator_values_to_out_queue(copy_accumulator_values_to_out_queue),
    .restart_out_queue(restart_out_queue), .out_valid(out_valid),
    .out_index(out_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Output vector: {in_ready, restart_inputs, reset_acc, copy, restart_oq, out_valid, busy, done, idx[2:0]}
  localparam logic [10:0] X_IDLE  = 11'h000;
  localparam logic [10:0] X_PREP  = 11'h310;
  localparam logic [10:0] X_FEED  = 11'h410;
  localparam logic [10:0] X_FLUSH = 11'h010;
  localparam logic [10:0] X_COPY  = 11'h3D0;
  localparam logic [10:0] X_ABORT = 11'h310;

  typedef struct {
    logic       start;
    logic       abort;
    logic [7:0] k;
    logic [10:0] exp;
  } row_t;

  row_t rows[$];

  function automatic logic [10:0] rd(input int i);
    logic [10:0] v;
    v = 11'h030 | 11'(i);
    if (i == 7) v = v | 11'h008;
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {in_ready, restart_inputs, reset_accumulators,
            copy_accumulator_values_to_out_queue, restart_out_queue,
            out_valid, busy, done, out_index};
  endfunction

  task automatic add(input logic s, input logic a, input logic [7:0] k, input logic [10:0] e);
    row_t r;
    r.start = s; r.abort = a; r.k = k; r.exp = e;
    rows.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      check($sformatf("row%0d", i), 32'(outs()), 32'(rows[i].exp));
      start    = rows[i].start;
      abort    = rows[i].abort;
      k_blocks = rows[i].k;
      step();
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    int n;
    // Tile with k=3: rows 0..18
    add(1, 0, 8'd3, X_IDLE);
    add(0, 0, 8'd0, X_PREP);
    for (int i = 0; i < 6; i++) add(0, 0, 8'd0, X_FEED);
    add(0, 0, 8'd0, X_FLUSH);
    add(0, 0, 8'd0, X_COPY);
    for (int i = 0; i < 8; i++) add(0, 0, 8'd0, rd(i));
    add(0, 0, 8'd0, X_IDLE);
    // k=0 tile, then abort in IDLE has no effect
    add(1, 0, 8'd0, X_IDLE);
    add(0, 0, 8'd0, X_PREP);
    add(0, 0, 8'd0, X_FLUSH);
    add(0, 0, 8'd0, X_COPY);
    for (int i = 0; i < 8; i++) add(0, 0, 8'd0, rd(i));
    add(0, 1, 8'd0, X_IDLE);
    // Abort on the 3rd feed cycle; then start+abort together in IDLE
    add(1, 0, 8'd3, X_IDLE);
    add(0, 0, 8'd0, X_PREP);
    add(0, 0, 8'd0, X_FEED);
    add(0, 0, 8'd0, X_FEED);
    add(0, 1, 8'd0, X_FEED);
    add(0, 0, 8'd0, X_ABORT);
    add(1, 1, 8'd0, X_IDLE);
    add(0, 1, 8'd0, X_PREP);
    add(0, 0, 8'd0, X_ABORT);
    // Start held through a whole tile; k changes while busy are ignored
    add(1, 0, 8'd1, X_IDLE);
    add(1, 0, 8'd0, X_PREP);
    add(1, 0, 8'd0, X_FEED);
    add(1, 0, 8'd0, X_FEED);
    add(1, 0, 8'd0, X_FLUSH);
    add(1, 0, 8'd0, X_COPY);
    for (int i = 0; i < 8; i++) add(1, 0, 8'd0, rd(i));
    add(1, 0, 8'd0, X_IDLE);
    add(0, 1, 8'd0, X_PREP);
    add(0, 0, 8'd0, X_ABORT);
    add(0, 0, 8'd0, X_IDLE);

    #2;
    check("reset_outputs", 32'(outs()), 32'(X_IDLE));
    step();
    reset = 1'b0;
    run_rows(0, rows.size() - 1);

    // Largest k: 255 blocks of 2 slices
    start = 1'b1; k_blocks = 8'd255;
    step();
    start = 1'b0;
    check("kmax_prep", 32'(outs()), 32'(X_PREP));
    step();
    n = 0;
    while (in_ready && n < 600) begin
      n++;
      step();
    end
    check("kmax_feed_cycles", 32'(n), 32'd510);
    check("kmax_flush", 32'(outs()), 32'(X_FLUSH));
    step();
    check("kmax_copy", 32'(outs()), 32'(X_COPY));
    n = 0;
    while (!done && n < 20) begin
      n++;
      step();
    end
    check("kmax_done_idx", 32'(out_index), 32'd7);
    step();
    check("kmax_idle", 32'(outs()), 32'(X_IDLE));

    // Async reset in the middle of readout
    start = 1'b1; k_blocks = 8'd1;
    step();
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_index == 3'd4) && n < 20) begin
      n++;
      step();
    end
    check("mid_readout_idx", 32'(outs()), 32'(rd(4)));
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(outs()), 32'(X_IDLE));
    step();
    reset = 1'b0;
    run_rows(0, 18);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
